// File: rtl/frame_builder_if.sv
// Frame builder bus bundle.
// Groups the build request fields, the payload input stream and the transmit
// byte stream so the builder and its user connect through one port.
//   master : request issuer / payload source / transmit sink
//   slave  : the frame builder itself
// Ports:
//   build_start, status_code, cmd_echo, is_read, addr, data_len : frame request
//   data_in, data_in_valid, data_in_ready                       : payload stream
//   tx_data, tx_valid, tx_ready                                 : frame byte stream
//   busy, build_done                                            : progress flags
interface frame_builder_if;
   logic        build_start;
   logic [7:0]  status_code;
   logic [7:0]  cmd_echo;
   logic        is_read;
   logic [31:0] addr;
   logic [7:0]  data_len;
   logic [7:0]  data_in;
   logic        data_in_valid;
   logic        data_in_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        build_done;

   modport master (
      output build_start, status_code, cmd_echo, is_read, addr, data_len,
      output data_in, data_in_valid, tx_ready,
      input  data_in_ready, tx_data, tx_valid, busy, build_done
   );

   modport slave (
      input  build_start, status_code, cmd_echo, is_read, addr, data_len,
      input  data_in, data_in_valid, tx_ready,
      output data_in_ready, tx_data, tx_valid, busy, build_done
   );
endinterface

// File: rtl/frame_builder.sv
// Response frame builder.
// Emits SOF, STATUS, CMD, [ADDR0..ADDR3 little-endian, DATA x len], CRC-8 as a
// byte stream through a registered valid/ready output. The bracketed part is
// present only for reads with status 0x00; a read with an illegal length is
// reported as status 0x04 without address or payload.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : frame_builder_if.slave (request fields, payload in, tx out, flags)
//
// state  | meaning
// IDLE   | waiting for build_start
// SOF    | SOF byte held in the output register
// STATUS | STATUS byte held
// CMD    | CMD byte held
// ADDR   | address bytes being loaded, byte_idx = next address byte
// DATA   | payload bytes being loaded, byte_idx = bytes loaded so far;
//        | CRC is loaded once byte_idx reaches the length
// CRC    | CRC byte held, waiting for its handshake
// DONE   | build_done pulse, back to IDLE
module frame_builder #(
   parameter logic [7:0] SOF_RESPONSE   = 8'h2D,
   parameter int         MAX_DATA_BYTES = 16
) (
   input  logic           clk,
   input  logic           rst,
   frame_builder_if.slave bus
);
   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_LEN_ERR = 8'h04;
   localparam logic [7:0] MAX_LEN    = 8'(MAX_DATA_BYTES);

   typedef enum logic [2:0] {IDLE, SOF, STATUS, CMD, ADDR, DATA, CRC, DONE} state_t;

   state_t      state;
   logic [7:0]  crc;
   logic [7:0]  byte_idx;
   logic [7:0]  status_q;
   logic [7:0]  cmd_q;
   logic [31:0] addr_q;
   logic [7:0]  len_q;
   logic        with_payload;
   logic [7:0]  tx_data_q;
   logic        tx_valid_q;
   logic        busy_q;
   logic        done_q;

   logic        can_load;
   logic        len_bad;
   logic [7:0]  eff_status;
   logic [7:0]  addr_byte;

   function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] b);
      logic [7:0] c;
      c = c_in ^ b;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   // The output register is free when empty or being drained this cycle.
   assign can_load   = !tx_valid_q || bus.tx_ready;
   assign len_bad    = (bus.data_len == 8'd0) || (bus.data_len > MAX_LEN);
   assign eff_status = (bus.is_read && len_bad) ? ST_LEN_ERR : bus.status_code;
   assign addr_byte  = addr_q[{byte_idx[1:0], 3'b000} +: 8];

   assign bus.data_in_ready = (state == DATA) && can_load && (byte_idx != len_q);
   assign bus.tx_data       = tx_data_q;
   assign bus.tx_valid      = tx_valid_q;
   assign bus.busy          = busy_q;
   assign bus.build_done    = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         crc          <= 8'h00;
         byte_idx     <= 8'h00;
         status_q     <= 8'h00;
         cmd_q        <= 8'h00;
         addr_q       <= 32'h0;
         len_q        <= 8'h00;
         with_payload <= 1'b0;
         tx_data_q    <= 8'h00;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.build_start) begin
                  status_q     <= eff_status;
                  cmd_q        <= bus.cmd_echo;
                  addr_q       <= bus.addr;
                  len_q        <= bus.data_len;
                  with_payload <= bus.is_read && (eff_status == ST_OK);
                  crc          <= 8'h00;
                  byte_idx     <= 8'h00;
                  tx_data_q    <= SOF_RESPONSE;
                  tx_valid_q   <= 1'b1;
                  busy_q       <= 1'b1;
                  state        <= SOF;
               end
            end
            SOF: begin
               if (can_load) begin
                  tx_data_q <= status_q;
                  crc       <= crc8_byte(crc, status_q);
                  state     <= STATUS;
               end
            end
            STATUS: begin
               if (can_load) begin
                  tx_data_q <= cmd_q;
                  crc       <= crc8_byte(crc, cmd_q);
                  state     <= CMD;
               end
            end
            CMD: begin
               if (can_load) begin
                  if (with_payload) begin
                     tx_data_q <= addr_q[7:0];
                     crc       <= crc8_byte(crc, addr_q[7:0]);
                     byte_idx  <= 8'd1;
                     state     <= ADDR;
                  end else begin
                     tx_data_q <= crc;
                     state     <= CRC;
                  end
               end
            end
            ADDR: begin
               if (can_load) begin
                  tx_data_q <= addr_byte;
                  crc       <= crc8_byte(crc, addr_byte);
                  if (byte_idx == 8'd3) begin
                     byte_idx <= 8'd0;
                     state    <= DATA;
                  end else begin
                     byte_idx <= byte_idx + 8'd1;
                  end
               end
            end
            DATA: begin
               if (can_load) begin
                  if (byte_idx == len_q) begin
                     tx_data_q  <= crc;
                     tx_valid_q <= 1'b1;
                     state      <= CRC;
                  end else if (bus.data_in_valid) begin
                     tx_data_q  <= bus.data_in;
                     tx_valid_q <= 1'b1;
                     crc        <= crc8_byte(crc, bus.data_in);
                     byte_idx   <= byte_idx + 8'd1;
                  end else begin
                     // payload source starved: leave a bubble on the line
                     tx_valid_q <= 1'b0;
                  end
               end
            end
            CRC: begin
               if (bus.tx_ready) begin
                  tx_valid_q <= 1'b0;
                  done_q     <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_frame_builder.sv
// Scoreboard bench for frame_builder: stimulus pushes the expected frame bytes
// (computed from the frame rules and a bit-serial CRC) into a queue, and an
// independent monitor pops and compares every accepted tx byte and build_done.
module tb_frame_builder;
   localparam logic [7:0] SOF = 8'h2D;
   localparam int DONE_MARK = -1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   frame_builder_if bus();

   frame_builder #(.SOF_RESPONSE(SOF), .MAX_DATA_BYTES(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int sb[$];
   int mq[$];
   logic [7:0] dq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: byte list from the frame rules, CRC shifted in bit by bit.
   function automatic void model_frame(input logic [7:0] st, input logic [7:0] cmd, input bit rd,
                                       input logic [31:0] a, input logic [7:0] len);
      logic [7:0] msg[$];
      logic [7:0] eff;
      logic [7:0] c;
      bit fb;
      c   = 8'h00;
      eff = (rd && (len == 0 || len > 16)) ? 8'h04 : st;
      msg.push_back(eff);
      msg.push_back(cmd);
      if (rd && eff == 8'h00) begin
         for (int i = 0; i < 4; i++) msg.push_back(8'(a >> (8 * i)));
         foreach (dq[i]) msg.push_back(dq[i]);
      end
      foreach (msg[i]) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ msg[i][b];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
      mq.delete();
      mq.push_back(int'(SOF));
      foreach (msg[i]) mq.push_back(int'(msg[i]));
      mq.push_back(int'(c));
      mq.push_back(DONE_MARK);
   endfunction

   // Monitor: compares every tx handshake and build_done against the scoreboard.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   initial begin
      int e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) check("tx_hold_under_stall", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
            if (bus.tx_valid && bus.tx_ready) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_tx_byte: got %0h expected none", bus.tx_data);
               end else begin
                  e = sb.pop_front();
                  check("tx_byte", 32'(bus.tx_data), e);
               end
            end
            if (bus.build_done) begin
               check("build_done_expected", (sb.size() != 0 && sb[0] == DONE_MARK), 1);
               if (sb.size() != 0 && sb[0] == DONE_MARK) void'(sb.pop_front());
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
         end
      end
   end

   task automatic drive(input bit long_f, input int k, input bit stall, input bit gap);
      bus.tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (long_f) begin
         if (k < dq.size()) begin
            bus.data_in       = dq[k];
            bus.data_in_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
         end else begin
            bus.data_in       = 8'h00;
            bus.data_in_valid = 1'b0;
         end
      end else begin
         bus.data_in       = 8'($urandom);
         bus.data_in_valid = 1'b1;
      end
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1 after the frame.
   task automatic run_frame(input logic [7:0] st, input logic [7:0] cmd, input bit rd,
                            input logic [31:0] a, input logic [7:0] len, input bit stall,
                            input bit gap, input int start_at, input int abort_at, input bit literal);
      int k = 0;
      int cyc = 0;
      bit took;
      bit saw_dir = 1'b0;
      bit long_f;
      long_f = rd && (len != 0) && (len <= 16) && (st == 8'h00);
      if (!literal) model_frame(st, cmd, rd, a, len);
      foreach (mq[i]) sb.push_back(mq[i]);
      bus.status_code = st;
      bus.cmd_echo    = cmd;
      bus.is_read     = rd;
      bus.addr        = a;
      bus.data_len    = len;
      bus.build_start = 1'b1;
      drive(long_f, k, stall, gap);
      @(posedge clk); #1;
      bus.build_start = 1'b0;
      check("sof_next_cycle", {bus.tx_valid, bus.tx_data}, {1'b1, SOF});
      check("busy_after_start", bus.busy, 1);
      while (sb.size() != 0) begin
         if (cyc > 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: got %0d bytes pending expected 0", sb.size());
            sb.delete();
            break;
         end
         cyc++;
         @(negedge clk);
         took = bus.data_in_valid && bus.data_in_ready;
         if (bus.data_in_ready && !long_f) saw_dir = 1'b1;
         @(posedge clk); #1;
         if (took) k++;
         if (abort_at > 0 && k >= abort_at) begin
            rst = 1'b1;
            #1;
            check("abort_tx_valid", bus.tx_valid, 0);
            check("abort_busy", bus.busy, 0);
            check("abort_data_in_ready", bus.data_in_ready, 0);
            sb.delete();
            bus.data_in_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         if (cyc == start_at) begin
            bus.build_start = 1'b1;
            bus.status_code = 8'($urandom);
            bus.cmd_echo    = 8'($urandom);
            bus.is_read     = 1'b1;
            bus.addr        = $urandom;
            bus.data_len    = 8'd2;
         end else begin
            bus.build_start = 1'b0;
         end
         drive(long_f, k, stall, gap);
      end
      if (long_f) check("payload_consumed", k, dq.size());
      else        check("no_data_in_ready", saw_dir, 0);
   endtask

   task automatic fill_dq(input int n);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      bus.build_start   = 1'b0;
      bus.status_code   = 8'h00;
      bus.cmd_echo      = 8'h00;
      bus.is_read       = 1'b0;
      bus.addr          = 32'h0;
      bus.data_len      = 8'h00;
      bus.data_in       = 8'h00;
      bus.data_in_valid = 1'b0;
      bus.tx_ready      = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx_valid", bus.tx_valid, 0);
      check("reset_tx_data", bus.tx_data, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_build_done", bus.build_done, 0);
      check("reset_data_in_ready", bus.data_in_ready, 0);
      rst = 1'b0;

      // Write response with CRC error status: literal expected bytes.
      dq.delete();
      mq.delete();
      mq.push_back(32'h2D); mq.push_back(32'h01); mq.push_back(32'hA0); mq.push_back(32'h7C);
      mq.push_back(DONE_MARK);
      run_frame(8'h01, 8'hA0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 0, 0, 1'b1);

      // Read of four bytes, straight and then with stalls and gaps.
      dq.delete();
      dq.push_back(8'h11); dq.push_back(8'h22); dq.push_back(8'h33); dq.push_back(8'h44);
      run_frame(8'h00, 8'h5A, 1'b1, 32'h12345678, 8'd4, 1'b0, 1'b0, 0, 0, 1'b0);
      run_frame(8'h00, 8'h5A, 1'b1, 32'h12345678, 8'd4, 1'b1, 1'b1, 0, 0, 1'b0);
      fill_dq(16);
      run_frame(8'h00, 8'hC3, 1'b1, $urandom, 8'd16, 1'b1, 1'b1, 0, 0, 1'b0);

      // Illegal lengths become LEN_ERR frames.
      dq.delete();
      run_frame(8'h00, 8'h31, 1'b1, $urandom, 8'd0, 1'b0, 1'b0, 0, 0, 1'b0);
      run_frame(8'h00, 8'h32, 1'b1, $urandom, 8'd17, 1'b1, 1'b0, 0, 0, 1'b0);

      // build_start while busy must not disturb the frame in progress.
      fill_dq(6);
      run_frame(8'h00, 8'h77, 1'b1, $urandom, 8'd6, 1'b1, 1'b1, 3, 0, 1'b0);
      dq.delete();
      run_frame(8'h09, 8'h78, 1'b0, $urandom, 8'd0, 1'b0, 1'b0, 2, 0, 1'b0);

      // Reset during DATA, then a clean frame on the first cycle after release.
      fill_dq(8);
      run_frame(8'h00, 8'h44, 1'b1, $urandom, 8'd8, 1'b1, 1'b1, 0, 3, 1'b0);
      fill_dq(3);
      run_frame(8'h00, 8'h45, 1'b1, 32'hCAFEF00D, 8'd3, 1'b0, 1'b0, 0, 0, 1'b0);

      // Randomized frames, back to back.
      for (int n = 0; n < 30; n++) begin
         logic [7:0] st;
         logic [7:0] len;
         bit rd;
         case ($urandom_range(0, 3))
            0, 1:    st = 8'h00;
            2:       st = 8'h01;
            default: st = 8'($urandom);
         endcase
         rd  = 1'($urandom_range(0, 1));
         len = 8'($urandom_range(0, 18));
         if (rd && st == 8'h00 && len != 0 && len <= 16) fill_dq(int'(len));
         else dq.delete();
         run_frame(st, 8'($urandom), rd, $urandom, len, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 4)) : 0,
                   0, 1'b0);
      end

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
